// File: rtl/pattern_match_fsm.sv
// Streaming pattern detector: state is the matched-prefix length, pulses match on completion.
// Define PM_OVERLAP_EN for KMP fallback (overlapping matches); default restarts after each match.
module pattern_match_fsm #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAT_LEN = 5,
    parameter logic [PAT_LEN*DATA_W-1:0] PATTERN = "Hello",
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         din_valid,
    input  logic [DATA_W-1:0]            din,
    output logic                         match,
    output logic                         led,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0] prog
);

    localparam int unsigned KW = $clog2(PAT_LEN + 1);
    typedef logic [KW-1:0] k_t;
    localparam k_t LastK = k_t'(PAT_LEN - 1);

    function automatic logic [DATA_W-1:0] sym(input int unsigned i);
        return PATTERN[(PAT_LEN-1-i)*DATA_W +: DATA_W];
    endfunction

`ifdef PM_OVERLAP_EN
    localparam int unsigned NB = PAT_LEN * PAT_LEN;

    // Bit [k*PAT_LEN+m] set when the first m symbols are a suffix of the first k symbols.
    function automatic logic [NB-1:0] calc_border();
        logic [NB-1:0] b;
        b = '0;
        for (int unsigned k = 0; k < PAT_LEN; k++) begin
            for (int unsigned m = 0; m <= k; m++) begin
                logic ok;
                ok = 1'b1;
                for (int unsigned i = 0; i < m; i++) begin
                    if (sym(i) != sym(k - m + i)) ok = 1'b0;
                end
                b[k*PAT_LEN+m] = ok;
            end
        end
        return b;
    endfunction

    localparam logic [NB-1:0] Border = calc_border();
`endif

    k_t               k_q, k_d, nxt;
    logic             match_q, match_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    int unsigned      kk;

    always_comb begin
        k_d     = k_q;
        match_d = 1'b0;
        led_d   = led_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        nxt     = '0;
        kk      = 32'(k_q);
        if (clr) begin
            k_d   = '0;
            led_d = 1'b0;
            cnt_d = '0;
        end else if (k_q > LastK) begin
            k_d = '0;
        end else if (din_valid) begin
            hit = (k_q == LastK) && (din == sym(PAT_LEN - 1));
`ifdef PM_OVERLAP_EN
            // Longest candidate wins: a prefix of length l fits if its first l-1 symbols border
            // the current match and din equals its last symbol.
            for (int unsigned l = 1; l < PAT_LEN; l++) begin
                if ((l - 1 <= kk) && Border[kk*PAT_LEN+l-1] && (din == sym(l - 1))) begin
                    nxt = k_t'(l);
                end
            end
`else
            if (hit) begin
                nxt = '0;
            end else if ((k_q != LastK) && (din == sym(kk))) begin
                nxt = k_q + k_t'(1);
            end else if (din == sym(0)) begin
                nxt = k_t'(1);
            end else begin
                nxt = '0;
            end
`endif
            k_d = nxt;
            if (hit) begin
                match_d = 1'b1;
                led_d   = ~led_q;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            match_q <= 1'b0;
            led_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            k_q     <= k_d;
            match_q <= match_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign led       = led_q;
    assign match_cnt = cnt_q;
    assign prog      = k_q;

endmodule

// File: tb/tb_pattern_match_fsm.sv
// Scoreboard bench: three instances (default, CNT_W=2, "abab") share one random/directed stream;
// a history-based reference model predicts prog/led/count and queues each expected match pulse.
module tb_pattern_match_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, din_valid;
    logic [7:0]  din;
    logic        m0, m1, m2, l0, l1, l2;
    logic [15:0] c0, c2;
    logic [1:0]  c1;
    logic [2:0]  p0, p1, p2;

    pattern_match_fsm u_dflt (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .match(m0), .led(l0), .match_cnt(c0), .prog(p0)
    );

    pattern_match_fsm #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .match(m1), .led(l1), .match_cnt(c1), .prog(p1)
    );

    pattern_match_fsm #(.PAT_LEN(4), .PATTERN("abab")) u_abab (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .match(m2), .led(l2), .match_cnt(c2), .prog(p2)
    );

    typedef struct {
        int cyc;
        bit led;
        int cnt;
    } exp_t;

    exp_t sb_q[3][$];
    int   hist[3][$];
    int   mk[3];
    bit   mled[3];
    int   mcnt[3];
    int   plen[3] = '{5, 5, 4};
    int   cmax[3] = '{65535, 3, 65535};
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic int sym(int d, int i);
        string s;
        s = (d == 2) ? "abab" : "Hello";
        return int'(s[i]);
    endfunction

    function automatic int act_prog(int d);
        return (d == 0) ? int'(p0) : (d == 1) ? int'(p1) : int'(p2);
    endfunction
    function automatic int act_led(int d);
        return (d == 0) ? int'(l0) : (d == 1) ? int'(l1) : int'(l2);
    endfunction
    function automatic int act_cnt(int d);
        return (d == 0) ? int'(c0) : (d == 1) ? int'(c1) : int'(c2);
    endfunction
    function automatic int act_match(int d);
        return (d == 0) ? int'(m0) : (d == 1) ? int'(m1) : int'(m2);
    endfunction

    task automatic check(string name, int d, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc%0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            hist[d].delete();
            mk[d]   = 0;
            mled[d] = 1'b0;
            mcnt[d] = 0;
        end
    endtask

    // Longest proper pattern prefix that ends the accepted history.
    function automatic int pref_len(int d);
        for (int l = plen[d] - 1; l >= 1; l--) begin
            if (hist[d].size() >= l) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < l; i++)
                    if (hist[d][hist[d].size()-l+i] != sym(d, i)) ok = 1'b0;
                if (ok) return l;
            end
        end
        return 0;
    endfunction

    task automatic model_accept(int d, int s);
        bit hit;
        exp_t e;
`ifdef PM_OVERLAP_EN
        hist[d].push_back(s);
        if (hist[d].size() > plen[d]) void'(hist[d].pop_front());
        hit = (hist[d].size() == plen[d]);
        for (int i = 0; i < hist[d].size(); i++)
            if (hist[d][i] != sym(d, i)) hit = 1'b0;
        mk[d] = pref_len(d);
`else
        hit = (mk[d] == plen[d] - 1) && (s == sym(d, plen[d] - 1));
        if (hit) mk[d] = 0;
        else if (mk[d] < plen[d] - 1 && s == sym(d, mk[d])) mk[d]++;
        else mk[d] = (s == sym(d, 0)) ? 1 : 0;
`endif
        if (hit) begin
            mled[d] = ~mled[d];
            if (mcnt[d] < cmax[d]) mcnt[d]++;
            e.cyc = cyc;
            e.led = mled[d];
            e.cnt = mcnt[d];
            sb_q[d].push_back(e);
        end
    endtask

    task automatic step(bit v, int s, bit c);
        din_valid = v;
        din       = 8'(s);
        clr       = c;
        @(posedge clk);
        cyc++;
        if (c) model_clear();
        else if (v) for (int d = 0; d < 3; d++) model_accept(d, s);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_clear();
        for (int d = 0; d < 3; d++) begin
            sb_q[d].delete();
            check("async_rst_prog", d, act_prog(d), 0);
            check("async_rst_match", d, act_match(d), 0);
            check("async_rst_led", d, act_led(d), 0);
            check("async_rst_cnt", d, act_cnt(d), 0);
        end
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    task automatic send_str(string s, int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, int'(s[i]), 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b0);
        end
    endtask

    // Monitor: every negedge compare state outputs; pop the scoreboard on each match pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("prog", d, act_prog(d), mk[d]);
            check("led", d, act_led(d), int'(mled[d]));
            check("match_cnt", d, act_cnt(d), mcnt[d]);
            if (act_match(d) == 1) begin
                if (sb_q[d].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_match dut%0d cyc%0d: got 1, expected 0", d, cyc);
                end else begin
                    exp_t e;
                    e = sb_q[d].pop_front();
                    check("match_latency", d, cyc, e.cyc);
                    check("match_led", d, act_led(d), int'(e.led));
                    check("match_cnt_at_pulse", d, act_cnt(d), e.cnt);
                end
            end else if (sb_q[d].size() > 0 && sb_q[d][0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_match dut%0d cyc%0d: got 0, expected 1", d, cyc);
                void'(sb_q[d].pop_front());
            end
        end
    end

    initial begin
        string alpha;
        alpha     = "Helloab";
        rst       = 1'b1;
        clr       = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_prog", d, act_prog(d), 0);
            check("reset_cnt", d, act_cnt(d), 0);
        end
        rst = 1'b0;

        send_str("Hello", 0);
        step(1'b0, 0, 1'b0);
        send_str("HHello", 0);
        send_str("ababab", 0);
        step(1'b0, 0, 1'b0);
        send_str("He", 3);
        send_str("llo", 0);
        step(1'b0, 0, 1'b1);
        for (int n = 0; n < 5; n++) send_str("Hello", 0);
        step(1'b0, 0, 1'b0);
        send_str("Hel", 0);
        pulse_reset();
        send_str("lo", 0);
        step(1'b1, int'("H"), 1'b1);
        step(1'b0, 0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                int s;
                s = int'(alpha[$urandom_range(0, 6)]);
                step($urandom_range(0, 3) != 0, s, $urandom_range(0, 79) == 0);
            end
            if ($urandom_range(0, 9) == 0) send_str("Hello", 0);
            if ($urandom_range(0, 9) == 0) send_str("abab", 0);
        end

        repeat (3) step(1'b0, 0, 1'b0);
        for (int d = 0; d < 3; d++) check("sb_drain", d, sb_q[d].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
